wb_stage: RTL and testbench

//  Writeback stage: the write-side counterpart of ID's register-file read port. Buffers results from
//  MEM/EX in a 2-entry FIFO, formats load data, and drives Rd / reg_write_data / reg_we into ID's

---
 rtl/wb_stage_pkg.sv | 22 ++
 rtl/load_fmt.sv | 31 +++
 rtl/wb_stage.sv | 160 ++++++++++++++++
 tb/tb_wb_stage.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_stage_pkg.sv
// Writeback stage shared definitions: result source codes,
// load funct3 codes and the buffered control bundle.
package wb_stage_pkg;

  localparam logic [1:0] WB_SRC_ALU  = 2'b00;
  localparam logic [1:0] WB_SRC_LOAD = 2'b01;
  localparam logic [1:0] WB_SRC_PC4  = 2'b10;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  typedef struct packed {
    logic [4:0] rd;
    logic [1:0] src;
    logic [2:0] funct3;
    logic [1:0] addr_lo;
  } wb_ctl_t;

endpackage

// File: rtl/load_fmt.sv
// Load formatter: extracts byte/half/word from the aligned memory
// word and sign/zero extends. Ports: funct3, addr_lo, word -> data.
module load_fmt
  import wb_stage_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [2:0]      funct3,
  input  logic [1:0]      addr_lo,
  input  logic [XLEN-1:0] word,
  output logic [XLEN-1:0] data
);

  logic [7:0]  b;
  logic [15:0] h;

  always_comb begin
    b    = word[{addr_lo, 3'b000} +: 8];
    // halfword lanes only; addr_lo[0] is ignored
    h    = addr_lo[1] ? word[31:16] : word[15:0];
    data = word;
    unique case (funct3)
      F3_LB:   data = {{(XLEN-8){b[7]}}, b};
      F3_LH:   data = {{(XLEN-16){h[15]}}, h};
      F3_LBU:  data = {{(XLEN-8){1'b0}}, b};
      F3_LHU:  data = {{(XLEN-16){1'b0}}, h};
      default: data = word;
    endcase
  end

endmodule

// File: rtl/wb_stage.sv
// Writeback stage: DEPTH-entry result FIFO feeding the ID register file
// write port (reg_we/Rd/reg_write_data), stall via wb_stall. Optional
// WB_FWD_EN adds fwd_valid/fwd_rd/fwd_data exposing the formatted head.
module wb_stage
  import wb_stage_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int DEPTH = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [4:0]      in_rd,
  input  logic [1:0]      in_src,
  input  logic [2:0]      in_funct3,
  input  logic [1:0]      in_addr_lo,
  input  logic [XLEN-1:0] in_alu_res,
  input  logic [XLEN-1:0] in_load_data,
  input  logic [XLEN-1:0] in_pc4,
  input  logic            wb_stall,
  output logic            reg_we,
  output logic [4:0]      Rd,
  output logic [XLEN-1:0] reg_write_data,
  output logic [31:0]     retire_cnt
`ifdef WB_FWD_EN
  ,
  output logic            fwd_valid,
  output logic [4:0]      fwd_rd,
  output logic [XLEN-1:0] fwd_data
`endif
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  wb_ctl_t         ctl_q [DEPTH];
  wb_ctl_t         ctl_d [DEPTH];
  logic [XLEN-1:0] alu_q [DEPTH];
  logic [XLEN-1:0] alu_d [DEPTH];
  logic [XLEN-1:0] ld_q  [DEPTH];
  logic [XLEN-1:0] ld_d  [DEPTH];
  logic [XLEN-1:0] pc4_q [DEPTH];
  logic [XLEN-1:0] pc4_d [DEPTH];

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic            we_q, we_d;
  logic [4:0]      rd_q, rd_d;
  logic [XLEN-1:0] data_q, data_d;
  logic [31:0]     ret_q, ret_d;

  logic            full, empty, push, pop;
  wb_ctl_t         head_ctl;
  logic [XLEN-1:0] head_ld;
  logic [XLEN-1:0] head_data;

  assign full     = (cnt_q == CW'(DEPTH));
  assign empty    = (cnt_q == '0);
  // ready depends only on occupancy, never on a same-cycle pop
  assign in_ready = !full;
  assign push     = in_valid && !full;
  assign pop      = !empty && !wb_stall;
  assign head_ctl = ctl_q[rd_ptr_q];

  load_fmt #(.XLEN(XLEN)) u_load_fmt (
    .funct3  (head_ctl.funct3),
    .addr_lo (head_ctl.addr_lo),
    .word    (ld_q[rd_ptr_q]),
    .data    (head_ld)
  );

  always_comb begin
    head_data = alu_q[rd_ptr_q];
    unique case (1'b1)
      (head_ctl.src == WB_SRC_LOAD): head_data = head_ld;
      (head_ctl.src == WB_SRC_PC4):  head_data = pc4_q[rd_ptr_q];
      default:                       head_data = alu_q[rd_ptr_q];
    endcase
  end

  always_comb begin
    ctl_d    = ctl_q;
    alu_d    = alu_q;
    ld_d     = ld_q;
    pc4_d    = pc4_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (push) begin
      ctl_d[wr_ptr_q] = '{rd: in_rd, src: in_src,
                          funct3: in_funct3,
                          addr_lo: in_addr_lo};
      alu_d[wr_ptr_q] = in_alu_res;
      ld_d[wr_ptr_q]  = in_load_data;
      pc4_d[wr_ptr_q] = in_pc4;
      wr_ptr_d        = wr_ptr_q + PW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end
    unique case ({push, pop})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_comb begin
    // x0 still retires but never raises the write enable
    we_d   = pop && (head_ctl.rd != 5'd0);
    rd_d   = pop ? head_ctl.rd : rd_q;
    data_d = pop ? head_data : data_q;
    ret_d  = ret_q + {31'b0, pop};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        ctl_q[i] <= '0;
        alu_q[i] <= '0;
        ld_q[i]  <= '0;
        pc4_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      we_q     <= 1'b0;
      rd_q     <= '0;
      data_q   <= '0;
      ret_q    <= '0;
    end else begin
      ctl_q    <= ctl_d;
      alu_q    <= alu_d;
      ld_q     <= ld_d;
      pc4_q    <= pc4_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      we_q     <= we_d;
      rd_q     <= rd_d;
      data_q   <= data_d;
      ret_q    <= ret_d;
    end
  end

  assign reg_we         = we_q;
  assign Rd             = rd_q;
  assign reg_write_data = data_q;
  assign retire_cnt     = ret_q;

`ifdef WB_FWD_EN
  assign fwd_valid = !empty && (head_ctl.rd != 5'd0);
  assign fwd_rd    = head_ctl.rd;
  assign fwd_data  = head_data;
`endif

endmodule

// File: tb/tb_wb_stage.sv
// Directed self-checking bench for wb_stage.
// Each task drives one scenario and checks inline.
module tb_wb_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  in_rd;
  logic [1:0]  in_src;
  logic [2:0]  in_funct3;
  logic [1:0]  in_addr_lo;
  logic [31:0] in_alu_res;
  logic [31:0] in_load_data;
  logic [31:0] in_pc4;
  logic        wb_stall;
  logic        reg_we;
  logic [4:0]  Rd;
  logic [31:0] reg_write_data;
  logic [31:0] retire_cnt;
`ifdef WB_FWD_EN
  logic        fwd_valid;
  logic [4:0]  fwd_rd;
  logic [31:0] fwd_data;
`endif

  int cmp = 0;
  int bad = 0;
  int exp_ret = 0;

  always #5 clk = ~clk;

  wb_stage dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .in_rd          (in_rd),
    .in_src         (in_src),
    .in_funct3      (in_funct3),
    .in_addr_lo     (in_addr_lo),
    .in_alu_res     (in_alu_res),
    .in_load_data   (in_load_data),
    .in_pc4         (in_pc4),
    .wb_stall       (wb_stall),
    .reg_we         (reg_we),
    .Rd             (Rd),
    .reg_write_data (reg_write_data),
    .retire_cnt     (retire_cnt)
`ifdef WB_FWD_EN
    ,
    .fwd_valid      (fwd_valid),
    .fwd_rd         (fwd_rd),
    .fwd_data       (fwd_data)
`endif
  );

  task automatic drive(input logic [4:0] rd, input logic [1:0] src,
                       input logic [2:0] f3, input logic [1:0] off,
                       input logic [31:0] alu, input logic [31:0] ld,
                       input logic [31:0] pc4);
    in_valid     = 1'b1;
    in_rd        = rd;
    in_src       = src;
    in_funct3    = f3;
    in_addr_lo   = off;
    in_alu_res   = alu;
    in_load_data = ld;
    in_pc4       = pc4;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    in_valid = 1'b0; wb_stall = 1'b0;
    in_rd = '0; in_src = '0; in_funct3 = '0; in_addr_lo = '0;
    in_alu_res = '0; in_load_data = '0; in_pc4 = '0;
    repeat (2) @(posedge clk);
    #1;
    if (reg_we !== 1'b0) begin $display("FAIL rst_we got %b want 0", reg_we); bad++; end
    cmp++;
    if (Rd !== 5'd0) begin $display("FAIL rst_rd got %0d want 0", Rd); bad++; end
    cmp++;
    if (reg_write_data !== 32'h0) begin $display("FAIL rst_data got %h want 0", reg_write_data); bad++; end
    cmp++;
    if (retire_cnt !== 32'h0) begin $display("FAIL rst_cnt got %0d want 0", retire_cnt); bad++; end
    cmp++;
    if (in_ready !== 1'b1) begin $display("FAIL rst_ready got %b want 1", in_ready); bad++; end
    cmp++;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_alu();
    @(negedge clk);
    drive(5'd2, 2'b00, 3'b000, 2'b00, 32'h0000_00F0, 32'h0, 32'h0);
    @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk); #1;
    exp_ret++;
    if (reg_we !== 1'b1) begin $display("FAIL alu_we got %b want 1", reg_we); bad++; end
    cmp++;
    if (Rd !== 5'd2) begin $display("FAIL alu_rd got %0d want 2", Rd); bad++; end
    cmp++;
    if (reg_write_data !== 32'h0000_00F0) begin $display("FAIL alu_data got %h want 000000f0", reg_write_data); bad++; end
    cmp++;
    if (retire_cnt !== 32'(exp_ret)) begin $display("FAIL alu_cnt got %0d want %0d", retire_cnt, exp_ret); bad++; end
    cmp++;
    @(posedge clk); #1;
    if (reg_we !== 1'b0) begin $display("FAIL alu_we_1cyc got %b want 0", reg_we); bad++; end
    cmp++;
  endtask

  task automatic test_loads();
    logic [2:0]  f3 [5]  = '{3'b000, 3'b100, 3'b001, 3'b101, 3'b010};
    logic [1:0]  off [5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    logic [31:0] exp [5] = '{32'hFFFF_FF80, 32'h0000_007F,
                             32'hFFFF_8081, 32'h0000_8081,
                             32'h8081_7F80};
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      drive(5'd3, 2'b01, f3[i], off[i], 32'h1234_5678, 32'h8081_7F80, 32'h0);
      @(negedge clk);
      in_valid = 1'b0;
      @(posedge clk); #1;
      exp_ret++;
      if (reg_we !== 1'b1 || reg_write_data !== exp[i]) begin
        $display("FAIL load%0d got we=%b data=%h want we=1 data=%h", i, reg_we, reg_write_data, exp[i]);
        bad++;
      end
      cmp++;
    end
    if (retire_cnt !== 32'(exp_ret)) begin $display("FAIL load_cnt got %0d want %0d", retire_cnt, exp_ret); bad++; end
    cmp++;
  endtask

  task automatic test_backpressure();
    @(negedge clk);
    wb_stall = 1'b1;
    drive(5'd6, 2'b00, 3'b000, 2'b00, 32'h11, 32'h0, 32'h0);
    @(negedge clk);
    drive(5'd7, 2'b00, 3'b000, 2'b00, 32'h22, 32'h0, 32'h0);
    @(negedge clk);
    if (in_ready !== 1'b0) begin $display("FAIL bp_full_ready got %b want 0", in_ready); bad++; end
    cmp++;
    drive(5'd8, 2'b00, 3'b000, 2'b00, 32'h33, 32'h0, 32'h0);
    @(negedge clk);
    in_valid = 1'b0;
    if (reg_we !== 1'b0) begin $display("FAIL bp_stall_we got %b want 0", reg_we); bad++; end
    cmp++;
    if (Rd !== 5'd3 || reg_write_data !== 32'h8081_7F80) begin
      $display("FAIL bp_hold got rd=%0d data=%h want rd=3 data=80817f80", Rd, reg_write_data);
      bad++;
    end
    cmp++;
    wb_stall = 1'b0;
    @(posedge clk); #1;
    if (reg_we !== 1'b1 || Rd !== 5'd6 || reg_write_data !== 32'h11) begin
      $display("FAIL bp_first got we=%b rd=%0d data=%h want 1/6/11", reg_we, Rd, reg_write_data);
      bad++;
    end
    cmp++;
    if (in_ready !== 1'b1) begin $display("FAIL bp_ready_back got %b want 1", in_ready); bad++; end
    cmp++;
    @(posedge clk); #1;
    if (reg_we !== 1'b1 || Rd !== 5'd7 || reg_write_data !== 32'h22) begin
      $display("FAIL bp_second got we=%b rd=%0d data=%h want 1/7/22", reg_we, Rd, reg_write_data);
      bad++;
    end
    cmp++;
    @(posedge clk); #1;
    exp_ret += 2;
    if (reg_we !== 1'b0) begin $display("FAIL bp_refused got we=%b rd=%0d want we=0", reg_we, Rd); bad++; end
    cmp++;
    if (retire_cnt !== 32'(exp_ret)) begin $display("FAIL bp_cnt got %0d want %0d", retire_cnt, exp_ret); bad++; end
    cmp++;
  endtask

  task automatic test_back_to_back();
    logic [4:0]  rds [3] = '{5'd9, 5'd10, 5'd11};
    logic [31:0] dat [3] = '{32'hA1, 32'hB2, 32'hC3};
    @(negedge clk);
    drive(rds[0], 2'b00, 3'b000, 2'b00, dat[0], 32'h0, 32'h0);
    @(negedge clk);
    drive(rds[1], 2'b00, 3'b000, 2'b00, dat[1], 32'h0, 32'h0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (i == 0) drive(rds[2], 2'b00, 3'b000, 2'b00, dat[2], 32'h0, 32'h0);
      else in_valid = 1'b0;
      if (reg_we !== 1'b1 || Rd !== rds[i] || reg_write_data !== dat[i]) begin
        $display("FAIL b2b%0d got we=%b rd=%0d data=%h want 1/%0d/%h", i, reg_we, Rd, reg_write_data, rds[i], dat[i]);
        bad++;
      end
      cmp++;
    end
    @(negedge clk);
    exp_ret += 3;
    if (reg_we !== 1'b0) begin $display("FAIL b2b_end got we=%b want 0", reg_we); bad++; end
    cmp++;
    if (retire_cnt !== 32'(exp_ret)) begin $display("FAIL b2b_cnt got %0d want %0d", retire_cnt, exp_ret); bad++; end
    cmp++;
  endtask

  task automatic test_x0();
    int seen = 0;
    @(negedge clk);
    drive(5'd0, 2'b00, 3'b000, 2'b00, 32'hDEAD_BEEF, 32'h0, 32'h0);
    @(negedge clk);
    in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      if (reg_we === 1'b1) seen++;
    end
    exp_ret++;
    if (seen != 0) begin $display("FAIL x0_we got %0d writes want 0", seen); bad++; end
    cmp++;
    if (retire_cnt !== 32'(exp_ret)) begin $display("FAIL x0_cnt got %0d want %0d", retire_cnt, exp_ret); bad++; end
    cmp++;
  endtask

  task automatic test_reset_midop();
    int seen = 0;
    @(negedge clk);
    drive(5'd5, 2'b00, 3'b000, 2'b00, 32'h55, 32'h0, 32'h0);
    @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk); #1;
    if (reg_we !== 1'b1 || Rd !== 5'd5) begin $display("FAIL mid_pre got we=%b rd=%0d want 1/5", reg_we, Rd); bad++; end
    cmp++;
    @(negedge clk);
    wb_stall = 1'b1;
    drive(5'd12, 2'b00, 3'b000, 2'b00, 32'h66, 32'h0, 32'h0);
    @(negedge clk);
    drive(5'd13, 2'b00, 3'b000, 2'b00, 32'h77, 32'h0, 32'h0);
    @(negedge clk);
    in_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    if (reg_we !== 1'b0 || Rd !== 5'd0 || reg_write_data !== 32'h0 || retire_cnt !== 32'h0) begin
      $display("FAIL mid_rst got we=%b rd=%0d data=%h cnt=%0d want all 0", reg_we, Rd, reg_write_data, retire_cnt);
      bad++;
    end
    cmp++;
    if (in_ready !== 1'b1) begin $display("FAIL mid_rst_ready got %b want 1", in_ready); bad++; end
    cmp++;
    @(negedge clk);
    rst_n = 1'b1;
    wb_stall = 1'b0;
    exp_ret = 0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      if (reg_we === 1'b1) seen++;
    end
    if (seen != 0) begin $display("FAIL mid_after got %0d writes want 0", seen); bad++; end
    cmp++;
    if (retire_cnt !== 32'h0) begin $display("FAIL mid_cnt got %0d want 0", retire_cnt); bad++; end
    cmp++;
  endtask

`ifdef WB_FWD_EN
  task automatic test_fwd();
    @(negedge clk);
    wb_stall = 1'b1;
    drive(5'd4, 2'b10, 3'b000, 2'b00, 32'h0, 32'h0, 32'h0000_0104);
    @(negedge clk);
    in_valid = 1'b0;
    if (fwd_valid !== 1'b1 || fwd_rd !== 5'd4 || fwd_data !== 32'h0000_0104) begin
      $display("FAIL fwd got v=%b rd=%0d data=%h want 1/4/00000104", fwd_valid, fwd_rd, fwd_data);
      bad++;
    end
    cmp++;
    wb_stall = 1'b0;
    @(posedge clk); #1;
    exp_ret++;
    if (reg_we !== 1'b1 || reg_write_data !== 32'h0000_0104) begin
      $display("FAIL fwd_wb got we=%b data=%h want 1/00000104", reg_we, reg_write_data);
      bad++;
    end
    cmp++;
    if (fwd_valid !== 1'b0) begin $display("FAIL fwd_empty got %b want 0", fwd_valid); bad++; end
    cmp++;
  endtask
`endif

  initial begin
    test_reset();
    test_alu();
    test_loads();
    test_backpressure();
    test_back_to_back();
    test_x0();
`ifdef WB_FWD_EN
    test_fwd();
`endif
    test_reset_midop();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, bad);
    $finish;
  end

endmodule
